// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared pointer widths, FIFO depth formula and Gray/binary conversions for the UART FIFO.
package uart_fifo_pkg;
  localparam int PTR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_PTR_WIDTH = 32;
  typedef logic [MAX_PTR_WIDTH-1:0] ptr_t;
  function automatic int fifo_depth(input int ptr_width);
    return 1 << (ptr_width - 1);
  endfunction
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction
  // Zero-extended inputs keep the upper result bits zero, so callers may truncate freely.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    for (int i = 0; i < MAX_PTR_WIDTH; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/uart_fifo_sync.sv
// uart_fifo_sync: 2-FF synchroniser with async active-low reset, shared by both FIFO domains.
module uart_fifo_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] s1_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      s1_q <= '0;
      q_o  <= '0;
    end else begin
      s1_q <= d_i;
      q_o  <= s1_q;
    end
endmodule

// File: rtl/uart_fifo_wr_ctrl.sv
// uart_fifo_wr_ctrl: UART TX FIFO write front end (skid buffer, exact occupancy gate, pointer conversion).
// Define UART_FIFO_WR_LEVEL_EN to add the registered o_wrc_level / o_wrc_afull outputs.
module uart_fifo_wr_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int PTR_WIDTH  = PTR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  i_fifo_wr_clk,
  input  logic                  i_fifo_wr_rst_n,
  input  logic                  i_wrc_valid,
  input  logic [DATA_WIDTH-1:0] i_wrc_data,
  output logic                  o_wrc_ready,
  input  logic [PTR_WIDTH-1:0]  i_wrc_wptr,
  input  logic [PTR_WIDTH-1:0]  i_wrc_rptr_gray,
  input  logic                  i_wrc_full,
  output logic                  o_wrc_winc,
  output logic [DATA_WIDTH-1:0] o_wrc_wdata,
  output logic [PTR_WIDTH-1:0]  o_wrc_wptr_conv,
  output logic [PTR_WIDTH-1:0]  o_wrc_rptr_conv,
`ifdef UART_FIFO_WR_LEVEL_EN
  output logic [PTR_WIDTH-1:0]  o_wrc_level,
  output logic                  o_wrc_afull,
`endif
  output logic                  o_wrc_err,
  input  logic                  i_wrc_err_clr
);
  localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(fifo_depth(PTR_WIDTH));
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  head_q, tail_q, ready_q, err_q;
  logic                  head_d, tail_d, ready_d, err_d;
  logic [1:0]            count_q, count_d;
  logic [PTR_WIDTH-1:0]  wptr_conv_q, wptr_conv_d, rptr_bin, used;
  logic                  push, pop, allowed;
  uart_fifo_sync #(.WIDTH(PTR_WIDTH)) u_rptr_sync (
    .clk_i  (i_fifo_wr_clk),
    .rst_n_i(i_fifo_wr_rst_n),
    .d_i    (i_wrc_rptr_gray),
    .q_o    (o_wrc_rptr_conv)
  );
  // The synchronised rptr can only be stale-low, so this occupancy is never optimistic.
  assign rptr_bin    = PTR_WIDTH'(gray2bin(ptr_t'(o_wrc_rptr_conv)));
  assign used        = i_wrc_wptr - rptr_bin;
  assign allowed     = used < DEPTH_P;
  assign push        = i_wrc_valid && ready_q;
  assign pop         = o_wrc_winc;
  assign o_wrc_winc  = (count_q != 2'd0) && allowed;
  assign o_wrc_wdata = mem_q[head_q];
  assign o_wrc_ready = ready_q;
  assign o_wrc_wptr_conv = wptr_conv_q;
  assign o_wrc_err   = err_q;
  always_comb begin
    count_d     = count_q + 2'(push) - 2'(pop);
    ready_d     = count_d != 2'd2;
    head_d      = head_q ^ pop;
    tail_d      = tail_q ^ push;
    wptr_conv_d = PTR_WIDTH'(bin2gray(ptr_t'(i_wrc_wptr)));
    err_d       = i_wrc_err_clr ? 1'b0 : (o_wrc_winc && i_wrc_full) ? 1'b1 : err_q;
  end
  always_ff @(posedge i_fifo_wr_clk or negedge i_fifo_wr_rst_n)
    if (!i_fifo_wr_rst_n) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= 2'd0;
      ready_q     <= 1'b1;
      wptr_conv_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) mem_q[tail_q] <= i_wrc_data;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      wptr_conv_q <= wptr_conv_d;
      err_q       <= err_d;
    end
`ifdef UART_FIFO_WR_LEVEL_EN
  localparam logic [PTR_WIDTH-1:0] AFULL_TH = DEPTH_P - PTR_WIDTH'(1);
  logic [PTR_WIDTH-1:0] level_q;
  logic                 afull_q;
  always_ff @(posedge i_fifo_wr_clk or negedge i_fifo_wr_rst_n)
    if (!i_fifo_wr_rst_n) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= used;
      afull_q <= used >= AFULL_TH;
    end
  assign o_wrc_level = level_q;
  assign o_wrc_afull = afull_q;
`endif
endmodule

// File: tb/tb_uart_fifo_wr_ctrl.sv
// tb_uart_fifo_wr_ctrl: directed and randomized checks of uart_fifo_wr_ctrl against a queue-based reference model.
module tb_uart_fifo_wr_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, valid, full, err_clr;
  logic [7:0] data;
  logic [3:0] wptr, rptr_gray;
  logic       ready, winc, err;
  logic [7:0] wdata;
  logic [3:0] wconv, rconv;
  logic [7:0] sq[$], pq[$], dq[$];
  logic [3:0] rhist[$];
  logic [3:0] exp_rconv, exp_wconv, rb;
  logic       exp_err, obs_winc;
  int         rd_mode, n_cmp, n_bad, k;
  bit         rnd_data;

  always #5 clk = ~clk;

  uart_fifo_wr_ctrl #(.PTR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .i_fifo_wr_clk  (clk),
    .i_fifo_wr_rst_n(rst_n),
    .i_wrc_valid    (valid),
    .i_wrc_data     (data),
    .o_wrc_ready    (ready),
    .i_wrc_wptr     (wptr),
    .i_wrc_rptr_gray(rptr_gray),
    .i_wrc_full     (full),
    .o_wrc_winc     (winc),
    .o_wrc_wdata    (wdata),
    .o_wrc_wptr_conv(wconv),
    .o_wrc_rptr_conv(rconv),
    .o_wrc_err      (err),
    .i_wrc_err_clr  (err_clr)
  );

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] x);
    logic [3:0] r;
    r[3] = x[3];
    for (int i = 2; i >= 0; i--) r[i] = r[i+1] ^ x[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] wp, input logic [3:0] rbin);
    rst_n = 1'b0;
    wptr = wp;
    rb = rbin;
    rptr_gray = g(rbin);
    sq.delete(); pq.delete(); dq.delete(); rhist.delete();
    rhist.push_back(4'd0); rhist.push_back(4'd0);
    exp_rconv = 4'd0; exp_wconv = 4'd0; exp_err = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  // One clock: compare DUT against the model, then advance the model across the edge.
  task automatic cyc();
    logic [3:0] used, w_old, rp;
    logic       ew, acc, fl, cl;
    logic [7:0] d;
    #2;
    used = wptr - g2b(exp_rconv);
    ew = (sq.size() != 0) && (used < 4'd8);
    check("ready", 32'(ready), 32'(sq.size() < 2));
    check("winc", 32'(winc), 32'(ew));
    if (ew) check("wdata", 32'(wdata), 32'(sq[0]));
    check("wptr_conv", 32'(wconv), 32'(exp_wconv));
    check("rptr_conv", 32'(rconv), 32'(exp_rconv));
    check("err", 32'(err), 32'(exp_err));
    obs_winc = winc;
    if (winc) dq.push_back(wdata);
    acc = valid && (sq.size() < 2);
    d = data; w_old = wptr; fl = full; cl = err_clr; rp = rptr_gray;
    @(posedge clk); #1;
    if (ew) begin
      void'(sq.pop_front());
      wptr = wptr + 4'd1;
    end
    if (acc) begin
      sq.push_back(d);
      pq.push_back(d);
      data = rnd_data ? 8'($urandom) : d + 8'd1;
    end
    exp_wconv = g(w_old);
    rhist.push_back(rp);
    exp_rconv = rhist[rhist.size()-2];
    if (rhist.size() > 4) void'(rhist.pop_front());
    exp_err = cl ? 1'b0 : (ew && fl) ? 1'b1 : exp_err;
    if ((rd_mode == 1 || (rd_mode == 2 && $urandom_range(0, 1) == 0)) && (wptr != rb)) begin
      rb = rb + 4'd1;
      rptr_gray = g(rb);
    end
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_len"}, 32'(dq.size()), 32'(pq.size()));
    for (int i = 0; i < dq.size() && i < pq.size(); i++) check({tag, "_byte"}, 32'(dq[i]), 32'(pq[i]));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    valid = 1'b0; full = 1'b0; err_clr = 1'b0; data = 8'h01;
    rd_mode = 0; rnd_data = 1'b0;
    do_reset(4'd0, 4'd0);
    // Fill an empty FIFO of depth 8; the ninth byte must stall.
    valid = 1'b1;
    repeat (14) cyc();
    check("t1_writes", 32'(dq.size()), 32'd8);
    for (int i = 0; i < dq.size(); i++) check("t1_order", 32'(dq[i]), 32'(i + 1));
    check("t1_err", 32'(err), 32'd0);
    // Free one slot; the write resumes after the two-stage sync.
    valid = 1'b0;
    rb = 4'd1; rptr_gray = g(rb);
    k = 0;
    cyc();
    while (!obs_winc && k < 10) begin k++; cyc(); end
    check("t2_sync_lat", 32'(k), 32'd2);
    check("t2_ninth", 32'(dq.size()), 32'd9);
    if (dq.size() == 9) check("t2_ninth_byte", 32'(dq[8]), 32'h09);
    // Pointer wrap around 15 -> 0 with rptr near the top.
    data = 8'h40;
    do_reset(4'd14, 4'd7);
    repeat (3) cyc();
    valid = 1'b1;
    repeat (6) cyc();
    check("t3_one_write", 32'(dq.size()), 32'd1);
    rb = 4'd8; rptr_gray = g(rb);
    repeat (6) cyc();
    check("t3_two_writes", 32'(dq.size()), 32'd2);
    #1 check("t3_wconv_wrap", 32'(wconv), 32'd0);
    // Drain, then toggle valid every cycle with a reader keeping up.
    valid = 1'b0; rd_mode = 1; rnd_data = 1'b1;
    repeat (15) cyc();
    for (int i = 0; i < 40; i++) begin
      valid = ~valid;
      #1 check("t4_ready_hold", 32'(ready), 32'd1);
      cyc();
    end
    valid = 1'b0;
    repeat (15) cyc();
    compare_logs("t4");
    // Sticky error: set, hold, clear, and clear beating a coincident set.
    valid = 1'b1; cyc(); valid = 1'b0;
    full = 1'b1; cyc(); full = 1'b0;
    #1 check("t5_err_set", 32'(err), 32'd1);
    repeat (3) begin cyc(); #1 check("t5_err_hold", 32'(err), 32'd1); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    #1 check("t5_err_clr", 32'(err), 32'd0);
    valid = 1'b1; cyc(); valid = 1'b0;
    full = 1'b1; err_clr = 1'b1; cyc(); full = 1'b0; err_clr = 1'b0;
    #1 check("t5_clr_wins", 32'(err), 32'd0);
    // Reset with a full FIFO and two bytes parked in the skid buffer.
    rd_mode = 0; valid = 1'b1;
    repeat (20) cyc();
    #1 check("t6_skid_full", 32'(ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(ready), 32'd1);
    check("t6_rst_winc", 32'(winc), 32'd0);
    check("t6_rst_wconv", 32'(wconv), 32'd0);
    check("t6_rst_rconv", 32'(rconv), 32'd0);
    valid = 1'b0;
    do_reset(4'd0, 4'd0);
    repeat (6) cyc();
    check("t6_no_stale", 32'(dq.size()), 32'd0);
    // Randomized traffic with a random-rate reader.
    rd_mode = 2;
    for (int i = 0; i < 300; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      cyc();
    end
    valid = 1'b0; rd_mode = 1;
    repeat (25) cyc();
    compare_logs("rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_fifo_wr_ctrl.md
Name: uart_fifo_wr_ctrl

Overview:
Write-domain front end of the UART TX async FIFO. It sits between the core-side byte producer and the write-pointer block.
- Accepts bytes over a valid/ready handshake into a 2-entry skid buffer.
- Gates FIFO writes with an exact occupancy check.
- Drives winc and write data to the memory.
- Supplies the write-pointer block's Gray-coded comparison pointers: its own wptr and a 2-FF-synchronised rptr.

Parameters:
- PTR_WIDTH, 4, pointer width including wrap bit; FIFO depth = 2^(PTR_WIDTH-1).
- DATA_WIDTH, 8, byte width written to FIFO memory.

Ports:
- i_fifo_wr_clk  in  1  write-domain clock
- i_fifo_wr_rst_n  in  1  async active-low reset
- i_wrc_valid  in  1  producer has a byte
- i_wrc_data  in  DATA_WIDTH  producer byte
- o_wrc_ready  out  1  skid buffer can accept
- i_wrc_wptr  in  PTR_WIDTH  binary write pointer from the write-pointer block
- i_wrc_rptr_gray  in  PTR_WIDTH  Gray read pointer, read-domain (asynchronous)
- i_wrc_full  in  1  registered full flag from the write-pointer block
- o_wrc_winc  out  1  write strobe to pointer block and memory
- o_wrc_wdata  out  DATA_WIDTH  memory write data (skid head)
- o_wrc_wptr_conv  out  PTR_WIDTH  registered Gray of i_wrc_wptr
- o_wrc_rptr_conv  out  PTR_WIDTH  synchronised Gray rptr
- o_wrc_err  out  1  sticky: winc issued while i_wrc_full high
- i_wrc_err_clr  in  1  synchronous clear of o_wrc_err

Behaviour:
Reset is i_fifo_wr_rst_n, asynchronous, active-low; the clock is i_fifo_wr_clk. All flops clear on reset:
- skid count 0, o_wrc_ready 1 (comes out of reset ready)
- o_wrc_wptr_conv 0, o_wrc_rptr_conv 0, both sync stages 0, o_wrc_err 0

Skid buffer:
- Two entries, head/tail index, count 0..2.
- o_wrc_ready is registered and equals (count_next < 2), so it never depends combinationally on i_wrc_valid.
- Push on i_wrc_valid && o_wrc_ready. Pop on o_wrc_winc.
- Simultaneous push and pop leaves the count unchanged; data order is preserved.

Occupancy:
- rptr_bin = gray2bin(o_wrc_rptr_conv).
- used = i_wrc_wptr - rptr_bin, modulo 2^PTR_WIDTH.
- allowed = (used < 2^(PTR_WIDTH-1)).
- Wrap-around is handled by the modulo subtraction; used == DEPTH means full.

Write:
- o_wrc_winc = (count != 0) && allowed, combinational.
- o_wrc_wdata = head entry.
- i_wrc_wptr advances the cycle after winc, so back-to-back writes are exact with zero bubbles.
- i_wrc_full is not used as a gate (it lags by 3 cycles). It is a cross-check only.

Pointer outputs:
- Rptr sync: 2-stage flop chain; o_wrc_rptr_conv is stage 2. Latency is 2 edges; pessimistic staleness only.
- o_wrc_wptr_conv <= bin2gray(i_wrc_wptr) every cycle: one cycle after the pointer, two after winc.

Error flag:
- o_wrc_err sets when o_wrc_winc && i_wrc_full.
- Clear has priority over set.

Reset mid-operation: skid contents are discarded and no winc is emitted during reset. The read domain must be reset concurrently.

Optional Feature:
Macro UART_FIFO_WR_LEVEL_EN.
- Defined: adds output o_wrc_level [PTR_WIDTH-1:0] = registered `used` (0..DEPTH), plus o_wrc_afull, high when used >= DEPTH-1. Both reset to 0.
- Undefined: neither port exists and there is no related logic.

Decomposition:
- Package uart_fifo_pkg: default PTR_WIDTH/DATA_WIDTH constants, bin2gray and gray2bin functions, depth localparam formula.
- Sub-module uart_fifo_sync: parameterised-width 2-FF synchroniser with async active-low reset. It is reused later by the read side.

Test Plan (PTR_WIDTH=4, DATA_WIDTH=8, depth 8):
1. Reset released, rptr_gray=0, valid held with data 0x01..0x08:
   - eight winc pulses with wdata 0x01..0x08 in order;
   - the 9th byte stalls, winc stays low;
   - err stays 0.
2. FIFO full, then rptr_gray stepped 0000->0001:
   - winc re-asserts exactly 2 cycles after the change (sync latency);
   - the 9th byte is written.
3. Wrap: wptr driven 1110->1111->0000 with rptr_bin 0111:
   - used is computed modulo 16;
   - winc allowed until used=8;
   - wptr_conv follows Gray 1001, 1000, 0000.
4. Producer toggles valid every cycle while winc continuous:
   - ready never drops;
   - no byte is lost or duplicated across 20 bytes.
5. Force i_wrc_full=1 during a winc:
   - err=1 next cycle and held;
   - err_clr pulse returns 0;
   - clear wins when coincident with a set.
6. Assert reset with 2 bytes in the skid:
   - ready=1, winc=0 immediately (async);
   - both pointer outputs are 0;
   - no stale byte is written after release.
